// File: rtl/dec_scan_pkg.sv
// dec_scan_pkg: shared types and constants for the decoder scan controller.
//   state_t   : controller states (GAP only reachable when DEC_SCAN_GAP_EN is defined)
//   SEL_W     : width of the decoder select code
//   NUM_LINES : number of decoder lines driven by the scan
//   MASK_W    : width of the skip mask (one bit per line)
package dec_scan_pkg;

  localparam int SEL_W     = 4;
  localparam int NUM_LINES = 16;
  localparam int MASK_W    = NUM_LINES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/dec_next_unmasked.sv
// dec_next_unmasked: combinational search for the next line whose mask bit is clear.
// Ports:
//   cur       (in)  current line index; search starts above it unless from_zero
//   mask      (in)  skip mask, bit i = 1 means line i is skipped
//   from_zero (in)  1 = search from line 0 inclusive, ignoring cur
//   nxt       (out) lowest qualifying line index (0 when none found)
//   found     (out) a qualifying line exists
module dec_next_unmasked
  import dec_scan_pkg::*;
(
  input  logic [SEL_W-1:0]  cur,
  input  logic [MASK_W-1:0] mask,
  input  logic              from_zero,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  // Scan downward so the last hit written is the lowest qualifying index.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!mask[i] && (from_zero || (i > int'(cur)))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec_scan_ctrl.sv
// dec_scan_ctrl: sequential driver for a 4x16 decoder. Strobes one line at a
// time with a programmable dwell, single-sweep or continuous, skipping masked lines.
// Optional build macro: DEC_SCAN_GAP_EN adds a one-cycle en=0 break-before-make
// gap on every line advance (sel already shows the new line during the gap).
// Ports:
//   clk       (in)  system clock, rising edge
//   rst       (in)  synchronous active-high reset
//   start     (in)  begin a sweep; only sampled in IDLE
//   stop      (in)  abort the sweep; beats start
//   mode      (in)  0 = single sweep, 1 = continuous wrap
//   div       (in)  dwell per line in cycles minus 1
//   skip_mask (in)  bit i = 1 skips line i
//   sel       (out) decoder select {A,B,C,D}, MSB first
//   en        (out) decoder enable
//   busy      (out) sweep active
//   done      (out) one-cycle pulse at the end of a single sweep
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; outputs idle, sel holds last line
// ST_DWELL | current line enabled, dwell counter counting down to zero
// ST_GAP   | one cycle with en=0 on the new line before its dwell begins
module dec_scan_ctrl
  import dec_scan_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [MASK_W-1:0] skip_mask,
  output logic [SEL_W-1:0]  sel,
  output logic              en,
  output logic              busy,
  output logic              done
);

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [MASK_W-1:0]  mask_q, mask_d;
  logic               mode_q, mode_d;
  logic [SEL_W-1:0]   sel_d;
  logic               en_d, busy_d, done_d;

  logic [MASK_W-1:0]  mask_in;
  logic [SEL_W-1:0]   first_idx, next_idx;
  logic               first_found, next_found;

  // In IDLE the live mask decides the first line; afterwards only the snapshot counts.
  assign mask_in = (state_q == ST_IDLE) ? skip_mask : mask_q;

  dec_next_unmasked u_first (
    .cur       (sel),
    .mask      (mask_in),
    .from_zero (1'b1),
    .nxt       (first_idx),
    .found     (first_found)
  );

  dec_next_unmasked u_next (
    .cur       (sel),
    .mask      (mask_in),
    .from_zero (1'b0),
    .nxt       (next_idx),
    .found     (next_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      sel     <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      sel     <= sel_d;
      en      <= en_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    sel_d   = sel;
    en_d    = en;
    busy_d  = busy;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          div_d  = div;
          mask_d = skip_mask;
          mode_d = mode;
          if (first_found) begin
            sel_d   = first_idx;
            en_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = div;
            state_d = ST_DWELL;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_DWELL: begin
        if (stop) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (next_found || mode_q) begin
          // Continuous wrap always finds a line: the sweep only starts if one exists.
          sel_d = next_found ? next_idx : first_idx;
          cnt_d = div_q;
`ifdef DEC_SCAN_GAP_EN
          en_d    = 1'b0;
          state_d = ST_GAP;
`endif
        end else begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

`ifdef DEC_SCAN_GAP_EN
      ST_GAP: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          en_d    = 1'b1;
          state_d = ST_DWELL;
        end
      end
`endif

      default: begin
        en_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// tb_dec_scan_ctrl: self-checking bench for dec_scan_ctrl. For each sweep the
// expected per-cycle output timeline is built from the line list and dwell
// length, then compared cycle by cycle while inputs are scrambled mid-sweep.
module tb_dec_scan_ctrl;

  localparam int DIV_W = 8;
`ifdef DEC_SCAN_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, stop, mode;
  logic [DIV_W-1:0] div;
  logic [15:0]      skip_mask;
  logic [3:0]       sel;
  logic             en, busy, done;

  always #5 clk = ~clk;

  dec_scan_ctrl #(.DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .div       (div),
    .skip_mask (skip_mask),
    .sel       (sel),
    .en        (en),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic       en;
    logic       busy;
    logic       done;
  } obs_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] model_sel;
  obs_t       tl[$];
  int         abort_eff;

  function automatic obs_t mk(input logic [3:0] s, input logic e, input logic b, input logic d);
    return {s, e, b, d};
  endfunction

  function automatic obs_t cur_obs();
    return {sel, en, busy, done};
  endfunction

  task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got sel=%0d en=%0b busy=%0b done=%0b, expected sel=%0d en=%0b busy=%0b done=%0b",
               tag, got.sel, got.en, got.busy, got.done, exp.sel, exp.en, exp.busy, exp.done);
    end
  endtask

  // Expected outputs for cycles k+1, k+2, ... after the start edge k.
  task automatic build_tl(input logic [DIV_W-1:0] d, input logic [15:0] m, input bit md,
                          input int abort_at, input bit abort_rst);
    int   lines[$];
    int   j;
    bit   first;
    obs_t last;
    tl.delete();
    for (int i = 0; i < 16; i++) if (!m[i]) lines.push_back(i);
    abort_eff = -1;
    if (lines.size() == 0) begin
      tl.push_back(mk(model_sel, 1'b0, 1'b0, 1'b1));
      tl.push_back(mk(model_sel, 1'b0, 1'b0, 1'b0));
    end else if (!md) begin
      for (int k = 0; k < lines.size(); k++) begin
        if (GAP && k > 0) tl.push_back(mk(4'(lines[k]), 1'b0, 1'b1, 1'b0));
        repeat (int'(d) + 1) tl.push_back(mk(4'(lines[k]), 1'b1, 1'b1, 1'b0));
      end
      tl.push_back(mk(4'(lines[lines.size()-1]), 1'b0, 1'b0, 1'b1));
      tl.push_back(mk(4'(lines[lines.size()-1]), 1'b0, 1'b0, 1'b0));
    end else begin
      j = 0;
      first = 1'b1;
      while (tl.size() <= abort_at) begin
        if (GAP && !first) tl.push_back(mk(4'(lines[j]), 1'b0, 1'b1, 1'b0));
        repeat (int'(d) + 1) tl.push_back(mk(4'(lines[j]), 1'b1, 1'b1, 1'b0));
        first = 1'b0;
        j = (j + 1) % lines.size();
      end
    end
    if (abort_at >= 0 && abort_at < tl.size() && tl[abort_at].busy) begin
      abort_eff = abort_at;
      while (tl.size() > abort_at + 1) void'(tl.pop_back());
      last = tl[abort_at];
      if (abort_rst) last.sel = 4'd0;
      tl.push_back(mk(last.sel, 1'b0, 1'b0, 1'b0));
      tl.push_back(mk(last.sel, 1'b0, 1'b0, 1'b0));
    end
    model_sel = tl[tl.size()-1].sel;
  endtask

  task automatic run_sweep(input string tag, input logic [DIV_W-1:0] d, input logic [15:0] m,
                           input bit md, input int abort_at, input bit abort_rst, input bit scramble);
    build_tl(d, m, md, abort_at, abort_rst);
    @(negedge clk);
    start = 1'b1; stop = 1'b0; div = d; skip_mask = m; mode = md;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < tl.size(); t++) begin
      if (t > 0) @(negedge clk);
      stop = 1'b0;
      rst  = 1'b0;
      check_obs(tag, cur_obs(), tl[t]);
      if (t == abort_eff) begin
        if (abort_rst) rst = 1'b1;
        else           stop = 1'b1;
      end
      // start during an active sweep must be ignored
      start = scramble && tl[t].busy && ($urandom_range(0, 3) == 0);
      if (scramble) begin
        div       = DIV_W'($urandom);
        skip_mask = 16'($urandom);
        mode      = 1'($urandom);
      end
    end
    start = 1'b0; stop = 1'b0; rst = 1'b0;
  endtask

  initial begin
    logic [15:0] m;
    bit          md;
    int          ab;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; div = '0; skip_mask = '0;
    model_sel = 4'd0;
    repeat (3) @(negedge clk);
    check_obs("reset", cur_obs(), mk(4'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;

    run_sweep("full_div2",    8'd2, 16'h0000, 1'b0, -1, 1'b0, 1'b0);
    run_sweep("ends_div0",    8'd0, 16'h7FFE, 1'b0, -1, 1'b0, 1'b0);
    run_sweep("cont_low4",    8'd0, 16'hFFF0, 1'b1, 13, 1'b0, 1'b0);
    run_sweep("all_masked",   8'd3, 16'hFFFF, 1'b0, -1, 1'b0, 1'b0);

    @(negedge clk);
    start = 1'b1; stop = 1'b1; div = 8'd1; skip_mask = 16'h0000; mode = 1'b0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_obs("start_stop", cur_obs(), mk(model_sel, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    check_obs("start_stop2", cur_obs(), mk(model_sel, 1'b0, 1'b0, 1'b0));

    // entry 16 is the middle cycle of line 5 with div=2
    run_sweep("rst_mid",      8'd2, 16'h0000, 1'b0, 16, 1'b1, 1'b0);
    run_sweep("restart_scr",  8'd1, 16'h0000, 1'b0, -1, 1'b0, 1'b1);

    for (int it = 0; it < 30; it++) begin
      case (it % 3)
        0:       m = 16'($urandom) & 16'($urandom);
        1:       m = 16'($urandom) | 16'($urandom);
        default: m = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      endcase
      md = 1'($urandom);
      if (md)                              ab = $urandom_range(0, 50);
      else if ($urandom_range(0, 2) == 0)  ab = $urandom_range(0, 40);
      else                                 ab = -1;
      run_sweep("random", 8'($urandom_range(0, 4)), m, md, ab, 1'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
